i2c_slave_teddy: RTL
====================

Name: i2c_slave_teddy

Overview:
Byte-level I2C target (responder) that answers one configurable 7-bit address. It is the counterpart of the team's I2C master path and serves as the bench responder for that path and as the on-board target behind an FPGA-side register/FIFO interface. Received write bytes are streamed out with a strobe. Bytes for read transfers are pulled from an upstream non-showahead FIFO (1-cycle q latency). No clock stretching, no 10-bit addressing, no general call.

Parameters:
SYNC_STAGES, 2, synchroniser depth on scl_i/sda_i
FILT_LEN, 3, consecutive equal samples required before a filtered line changes

Ports:
clk  in  1  system clock
n_rst  in  1  reset; synchronous, active-low
dev_addr  in  7  own address; static during a transaction
scl_i  in  1  SCL pin input
sda_i  in  1  SDA pin input
sda_oen  out  1  1 = drive SDA low (open drain; pin output value fixed at 0)
out_data  out  8  received byte, valid with out_ena
out_ena  out  1  1-cycle strobe per accepted write byte
out_first  out  1  high with out_ena for the first data byte after the address
out_full  in  1  downstream cannot accept; byte is NACKed and dropped
in_data  in  8  transmit byte, sampled 1 cycle after rd_req
in_empty  in  1  no transmit data available
rd_req  out  1  1-cycle pop request to the transmit FIFO
busy  out  1  1 from START to STOP

Behaviour:
- Reset (n_rst=0 at posedge clk): state IDLE; sync/filter flops = 1; sda_oen, out_ena, out_first, rd_req, busy = 0; out_data = 0.
- Line conditioning: SYNC_STAGES flops, then filter. Filtered value toggles after FILT_LEN equal samples. Edge pulses: scl_rise, scl_fall, sda_rise, sda_fall. Pin-to-event latency is SYNC_STAGES+FILT_LEN clocks. SCL low time must be at least that plus 4 clocks.
- START = sda_fall while filtered SCL is 1. STOP = sda_rise while filtered SCL is 1.
- START in any state, including repeated START: go to ADDR, bit count = 0, release SDA, busy = 1.
- STOP in any state: go to IDLE, release SDA in the same cycle, busy = 0.
- START and STOP cannot coincide.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- ADDR:
  - Shift SDA MSB-first on each scl_rise.
  - On the 8th rise, compare bits [7:1] with dev_addr and latch r_nw.
  - Mismatch → WAIT_STOP; SDA is never driven.
- ADDR_ACK (match):
  - On the scl_fall after the 8th bit, set sda_oen = 1.
  - If r_nw and !in_empty, pulse rd_req on the 9th scl_rise and load in_data into the tx shift register 1 cycle later. If in_empty, load 0xFF and do not pulse rd_req.
  - On the 9th scl_fall: write → sda_oen = 0, go to WR_BYTE. Read → sda_oen = ~tx[7], go to RD_BYTE.
- WR_BYTE:
  - Sample SDA on each scl_rise.
  - On the 8th rise, if !out_full: one cycle later out_data = byte, out_ena = 1, out_first = 1 only for the first byte since the latest START.
  - On the 8th fall: ACK (sda_oen = 1) if accepted, else keep released (NACK).
  - Go to WR_ACK.
- WR_ACK: on the 9th scl_fall, release SDA and go to WR_BYTE.
- RD_BYTE:
  - sda_oen = ~tx[bit]; it changes only on scl_fall.
  - After the 8th scl_fall, release SDA and go to RD_ACK.
- RD_ACK (sample master on 9th scl_rise):
  - Master ACK (SDA = 0): preload the next byte using the same rd_req/in_empty rules; on the 9th fall go to RD_BYTE.
  - Master NACK: no rd_req, SDA released, go to WAIT_STOP.
- WAIT_STOP: SDA released; leave only on START or STOP.
- Byte and bit counters wrap freely; there is no byte-count limit.
- Mid-operation reset: immediate return to the reset state. Any pending rd_req is cancelled and no out_ena is produced.

Decomposition:
- Package i2c_pkg:
  - state encoding localparams
  - ACK = 0 / NACK = 1
  - IDLE_BYTE = 8'hFF
  - BITS_PER_BYTE = 8
- Sub-module i2c_line_filter (synchroniser, glitch filter, rise/fall pulses), instantiated once for SCL and once for SDA.
- The FSM, shift registers and counters stay in i2c_slave_teddy.

Test Plan:
1. Write: dev_addr = 7'h50; master sends 0xA0, 0x12, 0x34, STOP → ACK on all three 9th clocks; out_data 0x12 with out_first = 1, then 0x34 with out_first = 0; busy falls after STOP.
2. Address mismatch: 0xA2 followed by two data bytes → sda_oen stays 0 for the whole transfer; zero out_ena, zero rd_req.
3. Read: 0xA1; FIFO holds 0x5A, 0xC3; master ACKs byte 1 and NACKs byte 2 → SDA shows 0x5A then 0xC3; exactly 2 rd_req pulses; SDA released after the NACK.
4. Read with in_empty = 1 → 0xFF transmitted; no rd_req pulses.
5. Write 0xA0, 0x11, then 0x22 with out_full = 1 → NACK on the third 9th clock; exactly one out_ena (0x11).
6. Combined scenario:
   - Sequence: 0xA0, 0x07, Sr, 0xA1, read one byte, NACK, STOP.
   - During the read, inject a 2-clock SCL low glitch (FILT_LEN = 3).
   - Required: out_first with 0x07; busy stays 1 across Sr; the glitch is ignored (bit count unchanged); one rd_req.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C target: FSM encodings, ACK polarity, idle byte.
package i2c_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_WR_BYTE   = 3'd3;
  localparam logic [2:0] ST_WR_ACK    = 3'd4;
  localparam logic [2:0] ST_RD_BYTE   = 3'd5;
  localparam logic [2:0] ST_RD_ACK    = 3'd6;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [7:0]  IDLE_BYTE     = 8'hFF;
  localparam int unsigned BITS_PER_BYTE = 8;

  // True when the bit counter is on the final bit of a byte.
  function automatic logic last_bit(input logic [2:0] cnt);
    return cnt == 3'(BITS_PER_BYTE - 1);
  endfunction

endpackage

// File: rtl/i2c_slave_teddy_if.sv
// Pin and byte-stream bundle between the I2C target and its surroundings.
interface i2c_slave_teddy_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oen;
  logic [7:0] out_data;
  logic       out_ena;
  logic       out_first;
  logic       out_full;
  logic [7:0] in_data;
  logic       in_empty;
  logic       rd_req;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, out_full, in_data, in_empty,
    output sda_oen, out_data, out_ena, out_first, rd_req, busy
  );

  modport master (
    output scl_i, sda_i, out_full, in_data, in_empty,
    input  sda_oen, out_data, out_ena, out_first, rd_req, busy
  );
endinterface

// File: rtl/i2c_line_filter.sv
// Synchroniser plus glitch filter for one I2C line, with registered edge pulses.
module i2c_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic pin_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Shift the pin through the synchroniser; flip the filtered level only after
  // FILT_LEN consecutive samples disagree with it.
  always_comb begin
    sync_d = (sync_q << 1) | SYNC_STAGES'(pin_i);
    filt_d = filt_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) begin
        filt_d = ~filt_q;
        rise_d = ~filt_q;
        fall_d = filt_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Line state registers; idle bus level is high.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_slave_teddy.sv
// Byte-level I2C target: one 7-bit address, write bytes streamed out, read
// bytes pulled from a 1-cycle-latency FIFO. No clock stretching.
module i2c_slave_teddy
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [6:0]          dev_addr,
  i2c_slave_teddy_if.slave    bus
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .n_rst(n_rst), .pin_i(bus.scl_i),
    .filt_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .n_rst(n_rst), .pin_i(bus.sda_i),
    .filt_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  logic       start, stop;
  logic [7:0] rx_next;

  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       r_nw_q, r_nw_d;
  logic       first_q, first_d;
  logic       accepted_q, accepted_d;
  logic       byte_done_q, byte_done_d;
  logic       ld_q, ld_d;
  logic       sda_oen_q, sda_oen_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_ena_q, out_ena_d;
  logic       out_first_q, out_first_d;
  logic       rd_req_q, rd_req_d;
  logic       busy_q, busy_d;

  assign start   = sda_fall & scl_f;
  assign stop    = sda_rise & scl_f;
  assign rx_next = {rx_q[6:0], sda_f};

  // Protocol FSM: bit shifting on filtered SCL edges, START/STOP override last.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    r_nw_d      = r_nw_q;
    first_d     = first_q;
    accepted_d  = accepted_q;
    byte_done_d = byte_done_q;
    sda_oen_d   = sda_oen_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    out_ena_d   = 1'b0;
    out_first_d = 1'b0;
    rd_req_d    = 1'b0;
    // FIFO q is valid the cycle after the pop request is seen.
    ld_d        = rd_req_q;
    if (ld_q) tx_d = bus.in_data;

    case (state_q)
      ST_ADDR: begin
        if (scl_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit(bit_cnt_q)) begin
            r_nw_d  = sda_f;
            state_d = (rx_q[6:0] == dev_addr) ? ST_ADDR_ACK : ST_WAIT_STOP;
          end
        end
      end
      ST_ADDR_ACK: begin
        // sda_oen still low means this fall is the one ending the address byte.
        if (scl_rise && r_nw_q) begin
          if (bus.in_empty) tx_d = IDLE_BYTE;
          else              rd_req_d = 1'b1;
        end
        if (scl_fall) begin
          if (!sda_oen_q) begin
            sda_oen_d = 1'b1;
          end else begin
            bit_cnt_d = '0;
            if (r_nw_q) begin
              sda_oen_d = ~tx_q[7];
              state_d   = ST_RD_BYTE;
            end else begin
              sda_oen_d = 1'b0;
              state_d   = ST_WR_BYTE;
            end
          end
        end
      end
      ST_WR_BYTE: begin
        if (scl_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit(bit_cnt_q)) begin
            byte_done_d = 1'b1;
            first_d     = 1'b0;
            accepted_d  = ~bus.out_full;
            if (!bus.out_full) begin
              out_data_d  = rx_next;
              out_ena_d   = 1'b1;
              out_first_d = first_q;
            end
          end
        end
        if (scl_fall && byte_done_q) begin
          byte_done_d = 1'b0;
          sda_oen_d   = accepted_q;
          state_d     = ST_WR_ACK;
        end
      end
      ST_WR_ACK: begin
        if (scl_fall) begin
          sda_oen_d = 1'b0;
          state_d   = ST_WR_BYTE;
        end
      end
      ST_RD_BYTE: begin
        if (scl_fall) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit(bit_cnt_q)) begin
            sda_oen_d = 1'b0;
            state_d   = ST_RD_ACK;
          end else begin
            tx_d      = {tx_q[6:0], 1'b0};
            sda_oen_d = ~tx_q[6];
          end
        end
      end
      ST_RD_ACK: begin
        if (scl_rise) begin
          if (sda_f == ACK) begin
            if (bus.in_empty) tx_d = IDLE_BYTE;
            else              rd_req_d = 1'b1;
          end else begin
            state_d = ST_WAIT_STOP;
          end
        end
        if (scl_fall) begin
          bit_cnt_d = '0;
          sda_oen_d = ~tx_q[7];
          state_d   = ST_RD_BYTE;
        end
      end
      default: ;
    endcase

    if (start) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = '0;
      sda_oen_d   = 1'b0;
      busy_d      = 1'b1;
      first_d     = 1'b1;
      byte_done_d = 1'b0;
    end else if (stop) begin
      state_d   = ST_IDLE;
      sda_oen_d = 1'b0;
      busy_d    = 1'b0;
    end
  end

  // State registers; reset cancels any pending pop, load or output strobe.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      r_nw_q      <= 1'b0;
      first_q     <= 1'b0;
      accepted_q  <= 1'b0;
      byte_done_q <= 1'b0;
      ld_q        <= 1'b0;
      sda_oen_q   <= 1'b0;
      out_data_q  <= '0;
      out_ena_q   <= 1'b0;
      out_first_q <= 1'b0;
      rd_req_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      r_nw_q      <= r_nw_d;
      first_q     <= first_d;
      accepted_q  <= accepted_d;
      byte_done_q <= byte_done_d;
      ld_q        <= ld_d;
      sda_oen_q   <= sda_oen_d;
      out_data_q  <= out_data_d;
      out_ena_q   <= out_ena_d;
      out_first_q <= out_first_d;
      rd_req_q    <= rd_req_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.sda_oen   = sda_oen_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ena   = out_ena_q;
  assign bus.out_first = out_first_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.busy      = busy_q;

endmodule
